// File: rtl/sccpu_trace_pkg.sv
// Shared definitions for the single-cycle CPU trace transmitter: record
// framing constants, flag bit positions, serializer states and the
// check-byte helper.
package sccpu_trace_pkg;

    localparam logic [7:0] TRACE_SYNC   = 8'hA5;
    localparam int         TRACE_BYTES  = 16;
    // Stored record = bytes 1..15 of the frame (seq, flags, PC, inst, value, check).
    localparam int         TRACE_REC_W  = 120;
    localparam int         TRACE_BODY_W = TRACE_REC_W - 8;

    localparam logic [3:0] TRACE_LAST_IDX = 4'(TRACE_BYTES - 1);

    // Bit positions inside the flags byte; bits 4:0 carry the destination register.
    localparam int FLAG_DWMEM  = 7;
    localparam int FLAG_DM2REG = 6;
    localparam int FLAG_DWREG  = 5;
    localparam int FLAG_RD_MSB = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    // XOR of every byte of the record body (frame bytes 1..14).
    function automatic logic [7:0] xor_bytes(input logic [TRACE_BODY_W-1:0] body);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < TRACE_BODY_W / 8; i++) begin
            acc = acc ^ body[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/sccpu_trace_tx_if.sv
// Byte-wide valid/ready stream from the trace transmitter to the host.
// The transmitter is the master; the host side is the slave.
interface sccpu_trace_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/sccpu_trace_fifo.sv
// Record FIFO for the trace transmitter. Pointers carry one extra wrap bit
// so that full and empty can be told apart. A push while full is accepted
// only when a pop happens in the same cycle.
module sccpu_trace_fifo
    import sccpu_trace_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [TRACE_REC_W-1:0] push_data,
    input  logic                   pop,
    output logic [TRACE_REC_W-1:0] pop_data,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [TRACE_REC_W-1:0] mem [DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointer advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sccpu_trace_tx.sv
// Trace transmitter for the single-cycle CPU. Every cycle with trace_en
// high turns the CPU debug outputs into a 16-byte record, queues it and
// streams it to the host one byte at a time over a valid/ready link.
// Build option SCCPU_TRACE_CHECKSUM_EN: when defined, byte 15 is the XOR
// of bytes 1..14; otherwise byte 15 is 0x00 and the XOR logic is absent.
module sccpu_trace_tx
    import sccpu_trace_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    trace_en,
    input  logic [31:0]             address,
    input  logic [31:0]             dinst,
    input  logic [4:0]              drd,
    input  logic                    dwreg,
    input  logic                    dm2reg,
    input  logic                    dwmem,
    input  logic [31:0]             eresult,
    input  logic [31:0]             mresult,
    input  logic [31:0]             wdata,
    sccpu_trace_tx_if.master        tx,
    output logic                    overflow,
    output logic [7:0]              drop_cnt,
    output logic                    busy
);

    logic [7:0]              seq;
    logic [31:0]             value;
    logic [7:0]              flags;
    logic [TRACE_BODY_W-1:0] body;
    logic [7:0]              check;
    logic [TRACE_REC_W-1:0]  rec_in;
    logic [TRACE_REC_W-1:0]  rec_out;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    accept;
    logic                    last;

    tx_state_t               state;
    logic [TRACE_REC_W-1:0]  shreg;
    logic [3:0]              idx;

    // Assemble the record for the current cycle from the CPU debug outputs.
    always_comb begin
        value = dwmem ? wdata : (dm2reg ? mresult : eresult);
        flags = 8'h00;
        flags[FLAG_DWMEM]       = dwmem;
        flags[FLAG_DM2REG]      = dm2reg;
        flags[FLAG_DWREG]       = dwreg;
        flags[FLAG_RD_MSB:0]    = drd;
        body  = {seq, flags, address, dinst, value};
`ifdef SCCPU_TRACE_CHECKSUM_EN
        check = xor_bytes(body);
`else
        check = 8'h00;
`endif
        rec_in = {body, check};
    end

    assign accept = (state == ST_SEND) && tx.tx_ready;
    assign last   = accept && (idx == TRACE_LAST_IDX);
    assign pop    = !fifo_empty && ((state == ST_IDLE) || last);
    assign push   = trace_en && (!fifo_full || pop);
    assign busy   = !fifo_empty || (state == ST_SEND);

    sccpu_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (rec_in),
        .pop       (pop),
        .pop_data  (rec_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sequence numbering of every attempt and bookkeeping of dropped records.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seq      <= 8'h00;
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
        end else if (trace_en) begin
            seq <= seq + 8'd1;
            if (!push) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // Serializer: load a record, emit sync byte then the stored bytes MSB first,
    // reloading straight from the FIFO after the last byte so records abut.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            idx         <= 4'd0;
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state       <= ST_SEND;
                        shreg       <= rec_out;
                        idx         <= 4'd0;
                        tx.tx_valid <= 1'b1;
                        tx.tx_data  <= TRACE_SYNC;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        if (idx == TRACE_LAST_IDX) begin
                            if (!fifo_empty) begin
                                shreg       <= rec_out;
                                idx         <= 4'd0;
                                tx.tx_valid <= 1'b1;
                                tx.tx_data  <= TRACE_SYNC;
                            end else begin
                                state       <= ST_IDLE;
                                shreg       <= '0;
                                idx         <= 4'd0;
                                tx.tx_valid <= 1'b0;
                                tx.tx_data  <= 8'h00;
                            end
                        end else begin
                            shreg      <= {shreg[TRACE_REC_W-9:0], 8'h00};
                            idx        <= idx + 4'd1;
                            tx.tx_data <= shreg[TRACE_REC_W-1 -: 8];
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    tx.tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccpu_trace_tx.sv
// Self-checking bench for sccpu_trace_tx. A queue-based model of the record
// stream runs alongside the DUT and every output is compared each cycle;
// directed scenarios add literal expectations on top of randomized traffic.
`timescale 1ns/1ps
module tb_sccpu_trace_tx;

    localparam int DEPTH = 8;

`ifdef SCCPU_TRACE_CHECKSUM_EN
    localparam logic [7:0] CHK_SINGLE = 8'h2E;
`else
    localparam logic [7:0] CHK_SINGLE = 8'h00;
`endif
    localparam logic [127:0] EXP_SINGLE = {120'hA5_00_23_00000010_00221820_00000007, CHK_SINGLE};

    logic        clock;
    logic        reset;
    logic        trace_en;
    logic [31:0] address;
    logic [31:0] dinst;
    logic [4:0]  drd;
    logic        dwreg;
    logic        dm2reg;
    logic        dwmem;
    logic [31:0] eresult;
    logic [31:0] mresult;
    logic [31:0] wdata;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        busy;

    sccpu_trace_tx_if txif();

    sccpu_trace_tx #(
        .DEPTH (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .trace_en (trace_en),
        .address  (address),
        .dinst    (dinst),
        .drd      (drd),
        .dwreg    (dwreg),
        .dm2reg   (dm2reg),
        .dwmem    (dwmem),
        .eresult  (eresult),
        .mresult  (mresult),
        .wdata    (wdata),
        .tx       (txif),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: pending records, record on the wire, counters.
    logic [127:0] mq[$];
    logic [127:0] mcur = '0;
    bit           mbusy = 1'b0;
    int           midx = 0;
    logic [7:0]   mseq = 8'h00;
    int           mdrops = 0;
    bit           movf = 1'b0;
    int           mocc;
    bit           mpop;

    // Bytes the DUT hands to the host, plus valid-cycle statistics.
    logic [7:0]   logq[$];
    int           cyc = 0;
    int           valid_cycles = 0;
    int           first_valid = -1;
    int           last_valid = -1;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [127:0] makeRecord(input logic [7:0] s, input logic wm, input logic m2,
                                                 input logic wr, input logic [4:0] rd, input logic [31:0] pc,
                                                 input logic [31:0] inst, input logic [31:0] ev,
                                                 input logic [31:0] mv, input logic [31:0] wv);
        logic [31:0]  v;
        logic [127:0] r;
        v = wm ? wv : (m2 ? mv : ev);
        r = {8'hA5, s, wm, m2, wr, rd, pc, inst, v, 8'h00};
`ifdef SCCPU_TRACE_CHECKSUM_EN
        begin
            logic [7:0] c;
            c = 8'h00;
            for (int k = 1; k < 15; k++) c = c ^ r[127-8*k -: 8];
            r[7:0] = c;
        end
`endif
        return r;
    endfunction

    function automatic logic [7:0] recByte(input logic [127:0] r, input int k);
        return r[127-8*k -: 8];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic [4:0] rd, input logic wr, input logic m2, input logic wm,
                                 input logic [31:0] ev, input logic [31:0] mv, input logic [31:0] wv);
        @(posedge clock);
        #2;
        trace_en = en;
        address  = pc;
        dinst    = inst;
        drd      = rd;
        dwreg    = wr;
        dm2reg   = m2;
        dwmem    = wm;
        eresult  = ev;
        mresult  = mv;
        wdata    = wv;
    endtask

    task automatic releaseEnable();
        @(posedge clock);
        #2;
        trace_en = 1'b0;
    endtask

    task automatic applyRandom(input logic en);
        applyStimulus(en, $urandom(), $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom());
    endtask

    task automatic applyReset();
        @(posedge clock);
        #3;
        reset    = 1'b0;
        trace_en = 1'b0;
        #1;
        checkOutput("reset_async_valid", 32'(txif.tx_valid), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        logq.delete();
        valid_cycles = 0;
        first_valid  = -1;
        last_valid   = -1;
    endtask

    task automatic waitLog(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (logq.size() < n && i < budget) begin
            @(negedge clock);
            #1;
            i++;
        end
        checkOutput(name, 32'(logq.size()), 32'(n));
    endtask

    // Reference model: advances the record stream on each rising edge.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mcur   = '0;
            mbusy  = 1'b0;
            midx   = 0;
            mseq   = 8'h00;
            mdrops = 0;
            movf   = 1'b0;
        end else begin
            mocc = mq.size();
            mpop = 1'b0;
            if (mbusy && txif.tx_ready) begin
                if (midx == 15) mbusy = 1'b0;
                else midx = midx + 1;
            end
            if (!mbusy && mocc > 0) begin
                mcur  = mq.pop_front();
                mbusy = 1'b1;
                midx  = 0;
                mpop  = 1'b1;
            end
            if (trace_en) begin
                if (mocc < DEPTH || mpop) begin
                    mq.push_back(makeRecord(mseq, dwmem, dm2reg, dwreg, drd, address, dinst,
                                            eresult, mresult, wdata));
                end else begin
                    movf = 1'b1;
                    if (mdrops < 255) mdrops = mdrops + 1;
                end
                mseq = mseq + 8'd1;
            end
        end
    end

    // Compare every output against the model away from the rising edge.
    always @(negedge clock) begin
        cyc++;
        checkOutput("tx_valid", 32'(txif.tx_valid), 32'(mbusy));
        if (mbusy) checkOutput("tx_data", 32'(txif.tx_data), 32'(recByte(mcur, midx)));
        checkOutput("busy", 32'(busy), 32'(mbusy || (mq.size() != 0)));
        checkOutput("overflow", 32'(overflow), 32'(movf));
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(mdrops));
        if (txif.tx_valid) begin
            valid_cycles++;
            if (first_valid < 0) first_valid = cyc;
            last_valid = cyc;
            if (txif.tx_ready) logq.push_back(txif.tx_data);
        end
    end

    initial begin
        logic [7:0] held;
        reset         = 1'b1;
        trace_en      = 1'b0;
        address       = '0;
        dinst         = '0;
        drd           = '0;
        dwreg         = 1'b0;
        dm2reg        = 1'b0;
        dwmem         = 1'b0;
        eresult       = '0;
        mresult       = '0;
        wdata         = '0;
        txif.tx_ready = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_tx_valid", 32'(txif.tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(txif.tx_data), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;

        // Single record with latency and exact byte content.
        $display("[TB] single record");
        applyReset();
        txif.tx_ready = 1'b1;
        applyStimulus(1'b1, 32'h0000_0010, 32'h0022_1820, 5'd3, 1'b1, 1'b0, 1'b0, 32'h7, 32'h0, 32'h0);
        releaseEnable();
        @(negedge clock);
        checkOutput("latency_k_valid", 32'(txif.tx_valid), 32'd0);
        checkOutput("latency_k_busy", 32'(busy), 32'd1);
        @(negedge clock);
        checkOutput("latency_k1_valid", 32'(txif.tx_valid), 32'd1);
        checkOutput("latency_k1_byte0", 32'(txif.tx_data), 32'hA5);
        waitLog(16, 100, "single_len");
        if (logq.size() >= 16) begin
            for (int i = 0; i < 16; i++) begin
                checkOutput($sformatf("single_b%0d", i), 32'(logq[i]), 32'(recByte(EXP_SINGLE, i)));
            end
        end

        // Backpressure mid-record.
        $display("[TB] backpressure");
        applyReset();
        txif.tx_ready = 1'b1;
        applyStimulus(1'b1, 32'h0040_0100, 32'h8C48_0004, 5'd8, 1'b1, 1'b1, 1'b0, 32'h11, 32'hCAFE_F00D, 32'h0);
        releaseEnable();
        waitLog(5, 100, "bp_first_bytes");
        @(posedge clock);
        #2;
        txif.tx_ready = 1'b0;
        @(negedge clock);
        held = txif.tx_data;
        checkOutput("bp_valid0", 32'(txif.tx_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("bp_hold_valid", 32'(txif.tx_valid), 32'd1);
            checkOutput("bp_hold_data", 32'(txif.tx_data), 32'(held));
        end
        @(posedge clock);
        #2;
        txif.tx_ready = 1'b1;
        waitLog(16, 100, "bp_len");
        if (logq.size() >= 16) begin
            checkOutput("bp_flags", 32'(logq[2]), 32'h68);
            checkOutput("bp_value_msb", 32'(logq[11]), 32'hCA);
            checkOutput("bp_value_lsb", 32'(logq[14]), 32'h0D);
            checkOutput("bp_pc_b6", 32'(logq[6]), 32'h00);
            checkOutput("bp_pc_b5", 32'(logq[5]), 32'h01);
        end

        // Back-to-back records without bubbles.
        $display("[TB] back-to-back");
        applyReset();
        txif.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) applyRandom(1'b1);
        releaseEnable();
        waitLog(48, 200, "b2b_len");
        repeat (4) @(negedge clock);
        checkOutput("b2b_valid_cycles", 32'(valid_cycles), 32'd48);
        checkOutput("b2b_span", 32'(last_valid - first_valid + 1), 32'd48);
        if (logq.size() >= 48) begin
            checkOutput("b2b_sync1", 32'(logq[16]), 32'hA5);
            checkOutput("b2b_sync2", 32'(logq[32]), 32'hA5);
            checkOutput("b2b_seq0", 32'(logq[1]), 32'd0);
            checkOutput("b2b_seq1", 32'(logq[17]), 32'd1);
            checkOutput("b2b_seq2", 32'(logq[33]), 32'd2);
        end

        // Overflow with the host stalled.
        $display("[TB] overflow");
        applyReset();
        txif.tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) applyRandom(1'b1);
        releaseEnable();
        @(negedge clock);
        checkOutput("ovf_drop_cnt", 32'(drop_cnt), 32'd11);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_busy", 32'(busy), 32'd1);
        @(posedge clock);
        #2;
        txif.tx_ready = 1'b1;
        waitLog(144, 400, "ovf_len");
        if (logq.size() >= 144) begin
            for (int r = 0; r < 9; r++) begin
                checkOutput($sformatf("ovf_seq%0d", r), 32'(logq[16*r+1]), 32'(r));
            end
        end
        repeat (5) @(negedge clock);
        checkOutput("ovf_drained_busy", 32'(busy), 32'd0);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        checkOutput("ovf_cnt_kept", 32'(drop_cnt), 32'd11);

        // Asynchronous reset during byte 7.
        $display("[TB] async reset");
        applyReset();
        txif.tx_ready = 1'b1;
        applyStimulus(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h5, 32'h0, 32'h0);
        releaseEnable();
        waitLog(7, 100, "ar_pre_len");
        @(posedge clock);
        #3;
        checkOutput("ar_pre_valid", 32'(txif.tx_valid), 32'd1);
        checkOutput("ar_pre_byte7", 32'(txif.tx_data), 32'h9A);
        reset = 1'b0;
        #1;
        checkOutput("ar_valid_drop", 32'(txif.tx_valid), 32'd0);
        checkOutput("ar_busy_drop", 32'(busy), 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        logq.delete();
        applyRandom(1'b1);
        releaseEnable();
        waitLog(16, 100, "ar_post_len");
        if (logq.size() >= 2) begin
            checkOutput("ar_post_sync", 32'(logq[0]), 32'hA5);
            checkOutput("ar_post_seq", 32'(logq[1]), 32'd0);
        end

        // Value select for stores and loads.
        $display("[TB] value select");
        applyReset();
        txif.tx_ready = 1'b1;
        applyStimulus(1'b1, 32'h100, 32'hAC00_0000, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1111, 32'h2222, 32'hDEAD_BEEF);
        releaseEnable();
        waitLog(16, 100, "store_len");
        if (logq.size() >= 16) begin
            checkOutput("store_flags", 32'(logq[2]), 32'h80);
            checkOutput("store_v0", 32'(logq[11]), 32'hDE);
            checkOutput("store_v1", 32'(logq[12]), 32'hAD);
            checkOutput("store_v2", 32'(logq[13]), 32'hBE);
            checkOutput("store_v3", 32'(logq[14]), 32'hEF);
        end
        logq.delete();
        applyStimulus(1'b1, 32'h104, 32'h8C00_0000, 5'd5, 1'b1, 1'b1, 1'b0, 32'h3333, 32'h1234_5678, 32'h4444);
        releaseEnable();
        waitLog(16, 100, "load_len");
        if (logq.size() >= 16) begin
            checkOutput("load_seq", 32'(logq[1]), 32'd1);
            checkOutput("load_flags", 32'(logq[2]), 32'h65);
            checkOutput("load_v0", 32'(logq[11]), 32'h12);
            checkOutput("load_v1", 32'(logq[12]), 32'h34);
            checkOutput("load_v2", 32'(logq[13]), 32'h56);
            checkOutput("load_v3", 32'(logq[14]), 32'h78);
        end

        // Drop counter saturation and sequence wrap.
        $display("[TB] saturation");
        applyReset();
        txif.tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) applyRandom(1'b1);
        releaseEnable();
        @(negedge clock);
        checkOutput("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        @(posedge clock);
        #2;
        txif.tx_ready = 1'b1;
        waitLog(144, 400, "sat_len");
        if (logq.size() >= 144) checkOutput("sat_last_seq", 32'(logq[129]), 32'd8);
        logq.delete();
        applyRandom(1'b1);
        releaseEnable();
        waitLog(16, 100, "wrap_len");
        if (logq.size() >= 2) checkOutput("wrap_seq", 32'(logq[1]), 32'd44);

        // Randomized traffic with random backpressure.
        $display("[TB] random traffic");
        applyReset();
        for (int i = 0; i < 3000; i++) begin
            applyRandom(1'($urandom_range(0, 11) == 0));
            txif.tx_ready = ($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 300; i++) begin
            applyRandom(1'($urandom_range(0, 1)));
            txif.tx_ready = 1'($urandom_range(0, 1));
        end
        releaseEnable();
        txif.tx_ready = 1'b1;
        repeat (400) @(posedge clock);
        @(negedge clock);
        checkOutput("random_drained", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
